// File: rtl/sprite_compositor.sv
// Sprite compositor: double-buffered sprite attribute banks and a 2-stage pixel pipeline
// that overlays up to NUM_SPRITES solid rectangles on a background colour.
module sprite_compositor #(
   parameter int          NUM_SPRITES = 4,
   parameter logic [11:0] BG_COLOR    = 12'h000,
   localparam int         IW          = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [9:0]    pixel_x,
   input  logic [9:0]    pixel_y,
   input  logic          vsync,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [IW-1:0] wr_idx,
   input  logic [9:0]    wr_x,
   input  logic [9:0]    wr_y,
   input  logic [9:0]    wr_w,
   input  logic [9:0]    wr_h,
   input  logic [11:0]   wr_color,
   input  logic          wr_en,
   output logic          frame_tick,
   output logic [3:0]    out_r,
   output logic [3:0]    out_g,
   output logic [3:0]    out_b
);

   typedef struct packed {
      logic        en;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [9:0]  w;
      logic [9:0]  h;
      logic [11:0] color;
   } slot_t;

   localparam slot_t SLOT_CLEAR = '{en: 1'b0, x: 10'd0, y: 10'd0, w: 10'd0, h: 10'd0, color: 12'h000};

   slot_t                  shadow_r [NUM_SPRITES];
   slot_t                  active_r [NUM_SPRITES];
   logic                   vsync_r;
   logic                   ready_en_r;
   logic                   commit_s;
   logic [NUM_SPRITES-1:0] hit_s;
   logic [11:0]            hit_color_s;
   logic                   blank_s;
   logic                   s1_blank_r;
   logic                   s1_hit_r;
   logic [11:0]            s1_color_r;

   // Edges are summed at 11 bits so a sprite near x=1023 cannot wrap to the left side.
   function automatic logic slot_hit(input slot_t s, input logic [9:0] px, input logic [9:0] py);
      logic [10:0] x_end;
      logic [10:0] y_end;
      x_end = {1'b0, s.x} + {1'b0, s.w};
      y_end = {1'b0, s.y} + {1'b0, s.h};
      return s.en && (s.w != 10'd0) && (s.h != 10'd0) &&
             ({1'b0, px} >= {1'b0, s.x}) && ({1'b0, px} < x_end) &&
             ({1'b0, py} >= {1'b0, s.y}) && ({1'b0, py} < y_end);
   endfunction

   assign commit_s = ~vsync & vsync_r;
   assign wr_ready = ready_en_r & ~commit_s;
   assign blank_s  = (pixel_x == 10'h3FF) || (pixel_y == 10'h3FF);

   // Per-slot hit test; scanning from the top slot down leaves the lowest-index hit's colour.
   always_comb begin
      hit_s       = {NUM_SPRITES{1'b0}};
      hit_color_s = BG_COLOR;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         hit_s[i] = slot_hit(active_r[i], pixel_x, pixel_y);
         if (hit_s[i]) begin
            hit_color_s = active_r[i].color;
         end else begin
            hit_color_s = hit_color_s;
         end
      end
   end

   // Vsync edge detection, write-ready enable and the post-commit frame pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_r    <= 1'b1;
         ready_en_r <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         vsync_r    <= vsync;
         ready_en_r <= 1'b1;
         frame_tick <= commit_s;
      end
   end

   // Shadow bank takes writes; active bank copies the whole shadow bank on a commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow_r[i] <= SLOT_CLEAR;
            active_r[i] <= SLOT_CLEAR;
         end
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (commit_s) begin
               active_r[i] <= shadow_r[i];
            end
            if (wr_valid && wr_ready && (wr_idx == IW'(i))) begin
               shadow_r[i] <= '{en: wr_en, x: wr_x, y: wr_y, w: wr_w, h: wr_h, color: wr_color};
            end
         end
      end
   end

   // Two-stage pixel pipeline; S1 captures the colour resolved against the bank it sampled.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_blank_r <= 1'b1;
         s1_hit_r   <= 1'b0;
         s1_color_r <= 12'h000;
         out_r      <= 4'h0;
         out_g      <= 4'h0;
         out_b      <= 4'h0;
      end else begin
         s1_blank_r <= blank_s;
         s1_hit_r   <= |hit_s;
         s1_color_r <= hit_color_s;
         if (s1_blank_r) begin
            {out_r, out_g, out_b} <= 12'h000;
         end else if (s1_hit_r) begin
            {out_r, out_g, out_b} <= s1_color_r;
         end else begin
            {out_r, out_g, out_b} <= BG_COLOR;
         end
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised and directed bench for sprite_compositor, checked every cycle against a
// frame-level model of the two attribute banks and the per-pixel colour rule.
module tb_sprite_compositor;

   localparam int          NS = 4;
   localparam logic [11:0] BG = 12'h135;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  pixel_x = 10'd0;
   logic [9:0]  pixel_y = 10'd0;
   logic        vsync = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [1:0]  wr_idx = 2'd0;
   logic [9:0]  wr_x = 10'd0, wr_y = 10'd0, wr_w = 10'd0, wr_h = 10'd0;
   logic [11:0] wr_color = 12'h000;
   logic        wr_en = 1'b0;
   logic        frame_tick;
   logic [3:0]  out_r, out_g, out_b;

   sprite_compositor #(.NUM_SPRITES(NS), .BG_COLOR(BG)) dut (
      .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .vsync(vsync),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
      .wr_w(wr_w), .wr_h(wr_h), .wr_color(wr_color), .wr_en(wr_en), .frame_tick(frame_tick),
      .out_r(out_r), .out_g(out_g), .out_b(out_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        en;
      int        x, y, w, h;
      bit [11:0] c;
   } mslot_t;

   mslot_t      m_act [NS];
   mslot_t      m_sh  [NS];
   bit          m_vs_prev = 1'b1;
   bit          m_ready_en = 1'b0;
   bit          m_tick = 1'b0;
   bit          m_started = 1'b0;
   logic [11:0] m_mid = 12'h000;
   logic [11:0] m_out = 12'h000;
   int          n_cmp = 0;
   int          n_err = 0;
   int          dut_ticks = 0;
   int          exp_ticks = 0;

   wire m_commit = !vsync && m_vs_prev;

   // Colour rule: blanking is black, otherwise the lowest-index covering slot, else background.
   function automatic logic [11:0] pix_color(input int px, input int py);
      if (px == 1023 || py == 1023) return 12'h000;
      for (int i = 0; i < NS; i++) begin
         if (m_act[i].en && m_act[i].w > 0 && m_act[i].h > 0 &&
             px >= m_act[i].x && px < m_act[i].x + m_act[i].w &&
             py >= m_act[i].y && py < m_act[i].y + m_act[i].h)
            return m_act[i].c;
      end
      return BG;
   endfunction

   always @(posedge clk) begin
      m_started <= 1'b1;
      if (reset) begin
         for (int i = 0; i < NS; i++) begin
            m_act[i] <= '{1'b0, 0, 0, 0, 0, 12'h000};
            m_sh[i]  <= '{1'b0, 0, 0, 0, 0, 12'h000};
         end
         m_vs_prev  <= 1'b1;
         m_ready_en <= 1'b0;
         m_tick     <= 1'b0;
         m_mid      <= 12'h000;
         m_out      <= 12'h000;
      end else begin
         m_mid <= pix_color(int'(pixel_x), int'(pixel_y));
         m_out <= m_mid;
         if (m_commit) begin
            for (int i = 0; i < NS; i++) m_act[i] <= m_sh[i];
         end
         if (wr_valid && m_ready_en && !m_commit)
            m_sh[wr_idx] <= '{wr_en, int'(wr_x), int'(wr_y), int'(wr_w), int'(wr_h), wr_color};
         m_tick     <= m_commit;
         m_vs_prev  <= vsync;
         m_ready_en <= 1'b1;
      end
   end

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (m_started) begin
            check("pixel", {out_r, out_g, out_b}, m_out);
            check("frame_tick", {11'd0, frame_tick}, {11'd0, m_tick});
            check("wr_ready", {11'd0, wr_ready}, {11'd0, m_ready_en && !m_commit});
            if (frame_tick === 1'b1) dut_ticks++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string name, input int x, input int y, input logic [11:0] req);
      vsync   = 1'b1;
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      tick();
      tick();
      check(name, {out_r, out_g, out_b}, req);
      check({name, "_model"}, m_out, req);
   endtask

   task automatic do_write(input int idx, input int x, input int y, input int w, input int h,
                           input logic [11:0] c, input logic en);
      bit got;
      got      = 1'b0;
      vsync    = 1'b1;
      wr_valid = 1'b1;
      wr_idx   = 2'(idx);
      wr_x     = 10'(x);
      wr_y     = 10'(y);
      wr_w     = 10'(w);
      wr_h     = 10'(h);
      wr_color = c;
      wr_en    = en;
      for (int k = 0; k < 20 && !got; k++) begin
         if (wr_ready) got = 1'b1;
         tick();
      end
      wr_valid = 1'b0;
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL write_timeout: got no wr_ready expected accept within 20 cycles");
      end
   endtask

   task automatic commit();
      vsync = 1'b0;
      repeat (3) tick();
      vsync = 1'b1;
      tick();
      exp_ticks++;
   endtask

   task automatic scan_random(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         pixel_x = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
         pixel_y = 10'($urandom_range(0, 1023));
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion expected $finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int vs_low;
      repeat (3) tick();
      reset = 1'b0;
      check("ready_first_cycle", {11'd0, wr_ready}, 12'd0);
      tick();
      check("ready_after_reset", {11'd0, wr_ready}, 12'd1);

      // idle frame: background everywhere, black in blanking
      scan_random(200);
      probe("idle_origin", 0, 0, BG);
      probe("idle_blank_x", 1023, 5, 12'h000);
      probe("idle_blank_y", 400, 1023, 12'h000);
      commit();

      // mid-frame write is deferred to the next frame
      do_write(0, 100, 50, 16, 8, 12'hF00, 1'b1);
      probe("deferred", 100, 50, BG);
      commit();
      probe("s0_tl", 100, 50, 12'hF00);
      probe("s0_br", 115, 57, 12'hF00);
      probe("s0_right", 116, 50, BG);
      probe("s0_below", 100, 58, BG);

      // priority between overlapping slots
      do_write(2, 190, 190, 20, 20, 12'h0F0, 1'b1);
      do_write(0, 195, 195, 10, 10, 12'hF00, 1'b1);
      commit();
      probe("overlap_prio", 200, 200, 12'hF00);
      do_write(0, 195, 195, 10, 10, 12'hF00, 1'b0);
      commit();
      probe("overlap_low", 200, 200, 12'h0F0);

      // write held across the vsync falling edge
      wr_idx = 2'd1; wr_x = 10'd300; wr_y = 10'd300; wr_w = 10'd5; wr_h = 10'd5;
      wr_color = 12'hABC; wr_en = 1'b1;
      vsync = 1'b0;
      wr_valid = 1'b1;
      #1;
      check("ready_commit_cycle", {11'd0, wr_ready}, 12'd0);
      tick();
      exp_ticks++;
      check("ready_after_commit", {11'd0, wr_ready}, 12'd1);
      tick();
      wr_valid = 1'b0;
      tick();
      probe("held_not_yet", 302, 302, BG);
      commit();
      probe("held_applied", 302, 302, 12'hABC);

      // edge geometry
      do_write(3, 790, 300, 100, 5, 12'h00F, 1'b1);
      do_write(1, 400, 400, 0, 10, 12'hF0F, 1'b1);
      do_write(2, 0, 0, 1, 1, 12'hFFF, 1'b1);
      commit();
      probe("clip_last", 799, 300, 12'h00F);
      probe("clip_first", 790, 300, 12'h00F);
      probe("clip_left", 789, 300, BG);
      probe("clip_nowrap", 5, 300, BG);
      probe("w0_never", 400, 400, BG);
      probe("px_00", 0, 0, 12'hFFF);
      probe("px_10", 1, 0, BG);
      probe("px_01", 0, 1, BG);
      check("tick_count", 12'(dut_ticks), 12'(exp_ticks));

      // randomised traffic with vsync glitches at arbitrary points
      vs_low = 0;
      for (int k = 0; k < 3000; k++) begin
         pixel_x  = ($urandom_range(0, 15) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
         pixel_y  = 10'($urandom_range(0, 1023));
         wr_valid = ($urandom_range(0, 2) == 0);
         wr_idx   = 2'($urandom_range(0, 3));
         wr_x     = 10'($urandom_range(0, 1023));
         wr_y     = 10'($urandom_range(0, 1023));
         wr_w     = 10'($urandom_range(0, 500));
         wr_h     = 10'($urandom_range(0, 500));
         wr_color = 12'($urandom);
         wr_en    = ($urandom_range(0, 3) != 0);
         if (vs_low > 0) begin
            vsync = 1'b0;
            vs_low--;
         end else begin
            vsync = 1'b1;
            if ($urandom_range(0, 60) == 0) vs_low = $urandom_range(1, 4);
         end
         tick();
      end
      wr_valid = 1'b0;
      vsync = 1'b1;
      tick();

      // reset mid-line with sprites visible
      do_write(0, 0, 0, 800, 600, 12'hE00, 1'b1);
      commit();
      probe("pre_reset", 10, 10, 12'hE00);
      reset = 1'b1;
      tick();
      check("reset_out", {out_r, out_g, out_b}, 12'h000);
      check("reset_ready", {11'd0, wr_ready}, 12'd0);
      tick();
      reset = 1'b0;
      scan_random(100);
      probe("post_reset_bg", 10, 10, BG);
      commit();
      probe("post_commit_bg", 10, 10, BG);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
